// File: rtl/cmd_handshake_tx.sv
// cmd_handshake_tx: queues command words in a circular FIFO and issues each one
// to a receiver over a four-phase req/ack handshake, with holdoff and timeout.
module cmd_handshake_tx #(
  parameter int WIDTH   = 3,
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk_50MHz,
  input  logic                     rst_n,
  input  logic                     clk_5Hz,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_instruction,
  output logic                     in_ready,
  input  logic                     ack,
  output logic                     req,
  output logic [WIDTH-1:0]         instruction,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, HOLD, REQ, REL} state_t;
  state_t           r_state, w_state;
  logic [1:0]       r_ack_s, r_tick_s;
  logic             r_tick_d;
  logic [AW:0]      r_wp, r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [7:0]       r_cnt, w_cnt, w_cnt_inc;
  logic [WIDTH-1:0] w_instr;
  logic             w_req, w_err, w_pop, w_push, w_tick, w_full, w_empty, w_ack;
  assign w_ack     = r_ack_s[1];
  assign w_tick    = r_tick_s[1] & ~r_tick_d;
  assign pending   = r_wp - r_rp;
  assign w_full    = pending == (AW+1)'(DEPTH);
  assign w_empty   = r_wp == r_rp;
  assign in_ready  = ~w_full;
  // a pop frees a slot in the same cycle, so a full FIFO can still take a word then
  assign w_push    = in_valid & (~w_full | w_pop);
  assign w_cnt_inc = (r_cnt == 8'hff) ? r_cnt : r_cnt + 8'd1;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_req   = req;
    w_instr = instruction;
    w_err   = timeout_err;
    w_pop   = 1'b0;
    case (r_state)
      IDLE: if (!w_empty && !w_ack) begin
        w_state = HOLD;
        w_cnt   = '0;
      end
      HOLD: if (int'(r_cnt) >= HOLDOFF) begin
        w_state = REQ;
        w_cnt   = '0;
        w_req   = 1'b1;
        w_instr = r_mem[r_rp[AW-1:0]];
      end else if (w_tick) w_cnt = w_cnt_inc;
      REQ: if (w_ack) begin
        w_state = REL;
        w_req   = 1'b0;
        w_pop   = 1'b1;
      end else if (w_tick && int'(w_cnt_inc) >= TIMEOUT) begin
        w_state = HOLD;
        w_req   = 1'b0;
        w_cnt   = '0;
        w_err   = 1'b1;
      end else if (w_tick) w_cnt = w_cnt_inc;
      REL: if (!w_ack) begin
        w_state = IDLE;
        w_instr = '0;
      end
    endcase
  end
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ack_s     <= '0;
      r_tick_s    <= '0;
      r_tick_d    <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      req         <= 1'b0;
      instruction <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_ack_s     <= {r_ack_s[0], ack};
      r_tick_s    <= {r_tick_s[0], clk_5Hz};
      r_tick_d    <= r_tick_s[1];
      r_wp        <= r_wp + (AW+1)'(w_push);
      r_rp        <= r_rp + (AW+1)'(w_pop);
      r_cnt       <= w_cnt;
      req         <= w_req;
      instruction <= w_instr;
      timeout_err <= w_err;
    end
  end
  always_ff @(posedge clk_50MHz)
    if (w_push) r_mem[r_wp[AW-1:0]] <= in_instruction;
endmodule
